avst_demultiplexer: RTL

- Packet-aware 1-to-2 Avalon-ST demultiplexer; the downstream stage of the two-input packet multiplexer.
- Takes the merged stream and routes each whole packet to output one or output two.
- Routing is decided by channel bit 0, sampled at the SOP beat.
- Each output has a one-entry registered slot, so throughput is 1 beat/cycle per path with 1-cycle latency.

---
 rtl/avst_demultiplexer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/avst_demultiplexer.sv
// Packet-aware 1-to-2 Avalon-ST demultiplexer. Each packet is routed whole
// to output one or output two by channel bit 0 of its SOP beat; each output
// has a single registered slot (1-cycle latency, 1 beat/cycle per path).
module avst_demultiplexer #(
  parameter int DATA_WIDTH    = 128,
  parameter int EMPTY_WIDTH   = 2,
  parameter int CHANNEL_WIDTH = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [CHANNEL_WIDTH-1:0] avsi_channel,
  input  logic [DATA_WIDTH-1:0]    avsi_data,
  input  logic                     avsi_valid,
  input  logic                     avsi_sop,
  input  logic                     avsi_eop,
  input  logic [EMPTY_WIDTH-1:0]   avsi_empty,
  output logic                     avsi_ready,
  output logic [CHANNEL_WIDTH-1:0] avso_one_channel,
  output logic [DATA_WIDTH-1:0]    avso_one_data,
  output logic                     avso_one_sop,
  output logic                     avso_one_eop,
  output logic [EMPTY_WIDTH-1:0]   avso_one_empty,
  output logic                     avso_one_valid,
  input  logic                     avso_one_ready,
  output logic [CHANNEL_WIDTH-1:0] avso_two_channel,
  output logic [DATA_WIDTH-1:0]    avso_two_data,
  output logic                     avso_two_sop,
  output logic                     avso_two_eop,
  output logic [EMPTY_WIDTH-1:0]   avso_two_empty,
  output logic                     avso_two_valid,
  input  logic                     avso_two_ready,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic [CNT_WIDTH-1:0]     err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FWD_ONE = 2'd1,
    FWD_TWO = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic one_valid_q, one_valid_d;
  logic two_valid_q, two_valid_d;
  logic [CHANNEL_WIDTH-1:0] one_channel_q, two_channel_q;
  logic [DATA_WIDTH-1:0]    one_data_q, two_data_q;
  logic                     one_sop_q, two_sop_q;
  logic                     one_eop_q, two_eop_q;
  logic [EMPTY_WIDTH-1:0]   one_empty_q, two_empty_q;
  logic [CNT_WIDTH-1:0]     drop_q, drop_d;
  logic [CNT_WIDTH-1:0]     err_q, err_d;

  logic can_load_one, can_load_two;
  logic sel, accept, ready;
  logic load_one, load_two;
  logic drop_inc, err_inc;

  assign can_load_one = ~one_valid_q | avso_one_ready;
  assign can_load_two = ~two_valid_q | avso_two_ready;
  assign sel          = avsi_channel[0];
  assign accept       = avsi_valid & ready;

  // Routing FSM: ready, slot loads, counter events and next state
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    load_one = 1'b0;
    load_two = 1'b0;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Non-SOP beats are always taken (and dropped) so orphans never stall.
        ready = ~avsi_sop | (sel ? can_load_two : can_load_one);
        if (accept) begin
          if (avsi_sop) begin
            load_one = ~sel;
            load_two = sel;
            if (!avsi_eop) state_d = sel ? FWD_TWO : FWD_ONE;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      FWD_ONE, FWD_TWO: begin
        ready = (state_q == FWD_ONE) ? can_load_one : can_load_two;
        if (accept) begin
          load_one = (state_q == FWD_ONE);
          load_two = (state_q == FWD_TWO);
          err_inc  = avsi_sop;
          if (avsi_eop) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot valid next-state: a load wins over a same-cycle drain
  always_comb begin
    one_valid_d = one_valid_q;
    two_valid_d = two_valid_q;
    if (load_one)            one_valid_d = 1'b1;
    else if (avso_one_ready) one_valid_d = 1'b0;
    if (load_two)            two_valid_d = 1'b1;
    else if (avso_two_ready) two_valid_d = 1'b0;
  end

  // Saturating counter next-state
  always_comb begin
    drop_d = drop_q;
    err_d  = err_q;
    if (drop_inc && (drop_q != '1)) drop_d = drop_q + 1'b1;
    if (err_inc && (err_q != '1))   err_d  = err_q + 1'b1;
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      one_valid_q <= 1'b0;
      two_valid_q <= 1'b0;
      drop_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      one_valid_q <= one_valid_d;
      two_valid_q <= two_valid_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  // Payload slots, unreset; contents only meaningful while valid
  always_ff @(posedge clk) begin
    if (load_one) begin
      one_channel_q <= avsi_channel;
      one_data_q    <= avsi_data;
      one_sop_q     <= avsi_sop;
      one_eop_q     <= avsi_eop;
      one_empty_q   <= avsi_empty;
    end
    if (load_two) begin
      two_channel_q <= avsi_channel;
      two_data_q    <= avsi_data;
      two_sop_q     <= avsi_sop;
      two_eop_q     <= avsi_eop;
      two_empty_q   <= avsi_empty;
    end
  end

  assign avsi_ready       = ready;
  assign avso_one_channel = one_channel_q;
  assign avso_one_data    = one_data_q;
  assign avso_one_sop     = one_sop_q;
  assign avso_one_eop     = one_eop_q;
  assign avso_one_empty   = one_empty_q;
  assign avso_one_valid   = one_valid_q;
  assign avso_two_channel = two_channel_q;
  assign avso_two_data    = two_data_q;
  assign avso_two_sop     = two_sop_q;
  assign avso_two_eop     = two_eop_q;
  assign avso_two_empty   = two_empty_q;
  assign avso_two_valid   = two_valid_q;
  assign drop_count       = drop_q;
  assign err_count        = err_q;

endmodule
